pico_io_ctrl: RTL and testbench

Handshake and operand-delivery controller between the DE0 switches and the `pico_mips` core. It synchronises and debounces the raw handshake switch and sequences a clean two-phase handshake. During the handshake it presents a latched, stable 8-bit operand on `in_bus`, and it counts completed operand transfers. It sits in the test top-level between `SW[9:0]` and the core's `io_handshake` / `in_bus` ports, and runs on the slow core clock.

---
 rtl/pico_io_pkg.sv | 13 +
 rtl/sync_debounce.sv | 81 ++++++++
 rtl/pico_io_ctrl.sv | 95 +++++++++
 tb/tb_pico_io_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pico_io_pkg.sv
// pico_io_ctrl shared types: FSM state encoding and operand width.
// Optional debounce is selected with PICO_IO_DEBOUNCE_EN.
package pico_io_pkg;

    localparam int IO_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        DONE = 2'd2
    } io_state_t;

endpackage

// File: rtl/sync_debounce.sv
// Handshake switch synchroniser with optional debounce filter.
// Debounce counter is built only when PICO_IO_DEBOUNCE_EN is defined.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic n_reset,
    input  logic hs_raw,
    output logic hs_clean,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= hs_raw;
            r_sync <= r_meta;
        end
    end

`ifdef PICO_IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_clean;
    logic          r_rise;
    logic          r_fall;

    assign w_cnt_nxt = r_cnt + 1'b1;

    // Count consecutive samples that disagree with the accepted level
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync == r_clean) begin
                r_cnt <= '0;
            end else if (w_cnt_nxt == DB_MAX) begin
                r_cnt   <= '0;
                r_clean <= r_sync;
                r_rise  <= r_sync;
                r_fall  <= ~r_sync;
            end else begin
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    assign hs_clean = r_clean;
    assign rise     = r_rise;
    assign fall     = r_fall;
`else
    logic r_clean;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_clean <= 1'b0;
        end else begin
            r_clean <= r_sync;
        end
    end

    assign hs_clean = r_clean;
    assign rise     = r_sync & ~r_clean;
    assign fall     = ~r_sync & r_clean;
`endif

endmodule

// File: rtl/pico_io_ctrl.sv
// Handshake sequencer and operand latch between DE0 switches and pico_mips.
// Build option: PICO_IO_DEBOUNCE_EN enables the handshake debounce filter.
module pico_io_ctrl
    import pico_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 hs_raw,
    input  logic [IO_DATA_W-1:0] data_raw,
    output logic                 io_handshake,
    output logic [IO_DATA_W-1:0] in_bus,
    output logic                 op_done,
    output logic [CNT_W-1:0]     op_count,
    output logic                 busy
);

    io_state_t            r_state;
    io_state_t            w_state_nxt;
    logic                 w_capture;
    logic                 w_hs_clean;
    logic                 w_rise;
    logic                 w_fall;
    logic [IO_DATA_W-1:0] r_dmeta;
    logic [IO_DATA_W-1:0] r_dsync;
    logic [IO_DATA_W-1:0] r_bus;
    logic [CNT_W-1:0]     r_count;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk     (clk),
        .n_reset (n_reset),
        .hs_raw  (hs_raw),
        .hs_clean(w_hs_clean),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_dmeta <= '0;
            r_dsync <= '0;
        end else begin
            r_dmeta <= data_raw;
            r_dsync <= r_dmeta;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = HELD;
                    w_capture   = 1'b1;
                end
            end
            HELD: begin
                if (w_fall) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand is latched on the same edge that raises the handshake
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
            r_bus   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_bus <= r_dsync;
            end
            if (r_state == DONE) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign io_handshake = (r_state == HELD);
    assign in_bus       = r_bus;
    assign op_done      = (r_state == DONE);
    assign op_count     = r_count;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_pico_io_ctrl.sv
// Self-checking bench for pico_io_ctrl against a sample-history model.
// Works with and without PICO_IO_DEBOUNCE_EN defined.
module tb_pico_io_ctrl;

    localparam int D  = 4;
    localparam int CW = 4;
`ifdef PICO_IO_DEBOUNCE_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam int LAT = DB ? (D + 2) : 2;

    logic          clk      = 1'b0;
    logic          n_reset  = 1'b0;
    logic          hs_raw   = 1'b0;
    logic [7:0]    data_raw = 8'h00;
    logic          io_handshake;
    logic [7:0]    in_bus;
    logic          op_done;
    logic [CW-1:0] op_count;
    logic          busy;

    pico_io_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .hs_raw      (hs_raw),
        .data_raw    (data_raw),
        .io_handshake(io_handshake),
        .in_bus      (in_bus),
        .op_done     (op_done),
        .op_count    (op_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: raw samples per edge since reset release, plus transfer state
    bit         hq[$];
    logic [7:0] dq[$];
    bit         m_clean;
    int         m_pe;
    int         m_st;
    logic [7:0] m_bus;
    int         m_cnt;

    wire [14:0] dut_vec = {io_handshake, in_bus, op_done, op_count, busy};

    function automatic bit hs_at(int i);
        return (i < 0) ? 1'b0 : hq[i];
    endfunction

    function automatic logic [7:0] d_at(int i);
        return (i < 0) ? 8'h00 : dq[i];
    endfunction

    function automatic logic [14:0] m_vec();
        return {m_st == 1, m_bus, m_st == 2, CW'(m_cnt), m_st != 0};
    endfunction

    task automatic model_reset();
        hq.delete();
        dq.delete();
        m_clean = 1'b0;
        m_pe    = 0;
        m_st    = 0;
        m_bus   = 8'h00;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        int n;
        bit v;
        bit all;
        hq.push_back(hs_raw);
        dq.push_back(data_raw);
        n = hq.size() - 1;
        case (m_st)
            0: if (m_pe == 1) begin
                m_st  = 1;
                m_bus = d_at(n - 2);
            end
            1: if (m_pe == 2) m_st = 2;
            default: begin
                m_st  = 0;
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
        endcase
        m_pe = 0;
        all  = 1'b1;
        if (DB) begin
            v = hs_at(n - 2);
            for (int j = n - 1 - D; j <= n - 2; j++)
                if (hs_at(j) != v) all = 1'b0;
        end else begin
            v = hs_at(n - 1);
        end
        if (all && v != m_clean) begin
            m_clean = v;
            m_pe    = v ? 1 : 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (n_reset) model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int rise_at;
        n_reset  = 1'b0;
        hs_raw   = 1'b1;
        data_raw = 8'hA5;
        model_reset();
        repeat (3) tick();
        checks++;
        if (dut_vec !== 15'h0000) begin
            errors++;
            $display("FAIL reset_hold got %h want 0000", dut_vec);
        end
        n_reset = 1'b1;
        rise_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (dut_vec !== m_vec()) begin
                errors++;
                $display("FAIL reset_cyc%0d got %h want %h", i, dut_vec, m_vec());
            end
            if (io_handshake && rise_at == 0) begin
                rise_at = i;
                checks++;
                if (in_bus !== 8'hA5) begin
                    errors++;
                    $display("FAIL reset_bus got %h want a5", in_bus);
                end
            end
        end
        checks++;
        if (rise_at != 1 + LAT) begin
            errors++;
            $display("FAIL reset_latency got %0d want %0d", rise_at, 1 + LAT);
        end
        hs_raw = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_clean();
        int hi;
        int dn;
        logic [CW-1:0] c0;
        hi = 0;
        dn = 0;
        c0 = op_count;
        data_raw = 8'h3C;
        for (int i = 0; i < 45; i++) begin
            hs_raw = (i < 20);
            tick();
            hi += int'(io_handshake);
            dn += int'(op_done);
            checks++;
            if (dut_vec !== m_vec()) begin
                errors++;
                $display("FAIL clean_cyc%0d got %h want %h", i, dut_vec, m_vec());
            end
        end
        checks++;
        if (hi != 20 || dn != 1) begin
            errors++;
            $display("FAIL clean_len got hi=%0d done=%0d want hi=20 done=1", hi, dn);
        end
        checks++;
        if (op_count !== CW'(c0 + 1'b1) || in_bus !== 8'h3C) begin
            errors++;
            $display("FAIL clean_cnt got %0d/%h want %0d/3c", op_count, in_bus, CW'(c0 + 1'b1));
        end
    endtask

    task automatic test_glitch(input int plen, input int phases);
        int hi;
        int exp_d;
        logic [CW-1:0] c0;
        hi = 0;
        c0 = op_count;
        for (int p = 0; p < phases; p++) begin
            hs_raw = ~p[0];
            repeat (plen) begin
                tick();
                hi += int'(io_handshake);
                checks++;
                if (dut_vec !== m_vec()) begin
                    errors++;
                    $display("FAIL glitch_p%0d got %h want %h", p, dut_vec, m_vec());
                end
            end
        end
        hs_raw = 1'b0;
        repeat (15) tick();
        exp_d = DB ? 0 : 1;
        if (plen > 1) exp_d = DB ? 0 : phases / 2;
        checks++;
        if (op_count !== CW'(c0 + exp_d)) begin
            errors++;
            $display("FAIL glitch_cnt got %0d want %0d", op_count, CW'(c0 + exp_d));
        end
`ifdef PICO_IO_DEBOUNCE_EN
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL bounce_hs got %0d high cycles want 0", hi);
        end
`endif
    endtask

    task automatic wait_hs(input string tag);
        int n;
        n = 0;
        while (!io_handshake && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (!io_handshake) begin
            errors++;
            $display("FAIL %s_timeout got hs=0 want hs=1", tag);
        end
    endtask

    task automatic test_data_held();
        data_raw = 8'h11;
        hs_raw   = 1'b1;
        wait_hs("held1");
        data_raw = 8'h22;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (in_bus !== 8'h11 || dut_vec !== m_vec()) begin
                errors++;
                $display("FAIL held_bus%0d got %h want 11", i, in_bus);
            end
        end
        hs_raw = 1'b0;
        repeat (15) tick();
        hs_raw = 1'b1;
        wait_hs("held2");
        checks++;
        if (in_bus !== 8'h22) begin
            errors++;
            $display("FAIL next_bus got %h want 22", in_bus);
        end
        hs_raw = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_random();
        int left;
        left = 0;
        for (int i = 0; i < 400; i++) begin
            if (left == 0) begin
                left     = $urandom_range(1, 10);
                hs_raw   = 1'($urandom_range(0, 1));
                data_raw = 8'($urandom);
            end
            left--;
            tick();
            checks++;
            if (dut_vec !== m_vec()) begin
                errors++;
                $display("FAIL rand_cyc%0d got %h want %h", i, dut_vec, m_vec());
            end
        end
        hs_raw = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_wrap_reset();
        logic [CW-1:0] c0;
        c0 = op_count;
        for (int t = 0; t < 16; t++) begin
            data_raw = 8'($urandom);
            for (int i = 0; i < 20; i++) begin
                hs_raw = (i < 10);
                tick();
                checks++;
                if (dut_vec !== m_vec()) begin
                    errors++;
                    $display("FAIL wrap_t%0d got %h want %h", t, dut_vec, m_vec());
                end
            end
        end
        checks++;
        if (op_count !== c0) begin
            errors++;
            $display("FAIL wrap_cnt got %0d want %0d", op_count, c0);
        end
        hs_raw = 1'b1;
        wait_hs("rst_held");
        #2 n_reset = 1'b0;
        #1 model_reset();
        checks++;
        if (dut_vec !== 15'h0000 || dut_vec !== m_vec()) begin
            errors++;
            $display("FAIL rst_held got %h want 0000", dut_vec);
        end
        hs_raw = 1'b0;
        @(negedge clk);
        checks++;
        if (op_done !== 1'b0 || io_handshake !== 1'b0) begin
            errors++;
            $display("FAIL rst_pulse got done=%b hs=%b want 0/0", op_done, io_handshake);
        end
        n_reset = 1'b1;
        repeat (10) tick();
        checks++;
        if (dut_vec !== m_vec()) begin
            errors++;
            $display("FAIL rst_after got %h want %h", dut_vec, m_vec());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_clean();
        test_glitch(2, 4);
        test_glitch(1, 1);
        test_data_held();
        test_random();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
